// File: rtl/bsg_comm_link_striper.sv
// Stripes fused core words across the active link channels and reassembles
// received chunks in order; the stripe position carries over from word to word.
module bsg_comm_link_striper #(
    parameter int channel_width_p = 16,
    parameter int core_channels_p = 3,
    parameter int link_channels_p = 4,
    parameter int width_p         = core_channels_p * channel_width_p
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       calib_done_i,
    input  logic [link_channels_p-1:0]                 active_channels_i,
    input  logic                                       fused_v_i,
    input  logic [width_p-1:0]                         fused_data_i,
    output logic                                       fused_ready_o,
    output logic                                       fused_v_o,
    output logic [width_p-1:0]                         fused_data_o,
    input  logic                                       fused_yumi_i,
    output logic [link_channels_p-1:0]                 link_v_o,
    output logic [link_channels_p*channel_width_p-1:0] link_data_o,
    input  logic [link_channels_p-1:0]                 link_ready_i,
    input  logic [link_channels_p-1:0]                 link_v_i,
    input  logic [link_channels_p*channel_width_p-1:0] link_data_i,
    output logic [link_channels_p-1:0]                 link_yumi_o
);
    localparam int CW = channel_width_p;
    localparam int LC = link_channels_p;
    localparam int IW = $clog2(core_channels_p + 1);
    localparam int PW = (link_channels_p > 1) ? $clog2(link_channels_p) : 1;
    localparam int NW = $clog2(link_channels_p + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [IW-1:0] idx_t;
    localparam idx_t LAST = idx_t'(core_channels_p);

    // Next higher active channel after p, wrapping to the lowest one.
    function automatic ptr_t next_ch(input ptr_t p, input logic [LC-1:0] m);
        ptr_t c;
        next_ch = p;
        for (int j = LC; j >= 1; j--) begin
            c = ptr_t'((int'(p) + j) % LC);
            if (m[c]) next_ch = c;
        end
    endfunction

    function automatic ptr_t lowest_ch(input logic [LC-1:0] m);
        lowest_ch = '0;
        for (int i = LC - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = ptr_t'(i);
        end
    endfunction

    logic [LC-1:0]      mask_q, mask_d;
    logic [NW-1:0]      n_active;
    logic               link_up;

    logic               tx_full_q, tx_full_d;
    idx_t               tx_k_q, tx_k_d, tx_m;
    ptr_t               tx_ptr_q, tx_ptr_d, tx_cur;
    logic [width_p-1:0] tx_data_q, tx_data_d;
    logic               tx_run;

    idx_t               rx_r_q, rx_r_d, rx_m;
    ptr_t               rx_ptr_q, rx_ptr_d, rx_cur;
    logic [width_p-1:0] rx_asm_q, rx_asm_d, rx_asm_n;
    logic [LC-1:0]      rx_y;
    logic               rx_run, rx_done, rx_stall;
    logic               out_full_q, out_full_d;
    logic [width_p-1:0] out_data_q, out_data_d;

    assign mask_d = calib_done_i ? mask_q : active_channels_i;

    always_comb begin
        n_active = '0;
        for (int i = 0; i < LC; i++) n_active = n_active + NW'(mask_q[i]);
    end

    assign link_up       = calib_done_i && (n_active != '0);
    assign fused_ready_o = link_up && !tx_full_q;
    assign fused_v_o     = out_full_q;
    assign fused_data_o  = out_data_q;

    // TX: walk the rotation from tx_ptr while channels stay ready.
    // NOTE: every variable gets a default before the loop, otherwise always_comb infers a latch.
    always_comb begin
        link_v_o    = '0;
        link_data_o = '0;
        tx_cur      = tx_ptr_q;
        tx_m        = '0;
        tx_run      = link_up && tx_full_q;
        for (int i = 0; i < LC; i++) begin
            if (tx_run && (i < int'(n_active)) && (tx_m < (LAST - tx_k_q)) && link_ready_i[tx_cur]) begin
                link_v_o[tx_cur] = 1'b1;
                link_data_o[int'(tx_cur)*CW +: CW] = tx_data_q[int'(tx_k_q + tx_m)*CW +: CW];
                tx_m   = tx_m + idx_t'(1);
                tx_cur = next_ch(tx_cur, mask_q);
            end else begin
                tx_run = 1'b0;
            end
        end
    end

    always_comb begin
        tx_full_d = tx_full_q;
        tx_k_d    = tx_k_q;
        tx_ptr_d  = tx_ptr_q;
        tx_data_d = tx_data_q;
        if (!calib_done_i) begin
            tx_full_d = 1'b0;
            tx_k_d    = '0;
            tx_ptr_d  = lowest_ch(active_channels_i);
            tx_data_d = '0;
        end else if (tx_full_q) begin
            tx_k_d   = tx_k_q + tx_m;
            tx_ptr_d = tx_cur;
            if (tx_k_d == LAST) tx_full_d = 1'b0;
        end else if (fused_v_i && fused_ready_o) begin
            tx_full_d = 1'b1;
            tx_k_d    = '0;
            tx_data_d = fused_data_i;
        end
    end

    // RX: same prefix walk on link_v_i; a completing word waits for output space.
    always_comb begin
        rx_y     = '0;
        rx_cur   = rx_ptr_q;
        rx_m     = '0;
        rx_asm_n = rx_asm_q;
        rx_run   = link_up;
        for (int i = 0; i < LC; i++) begin
            if (rx_run && (i < int'(n_active)) && (rx_m < (LAST - rx_r_q)) && link_v_i[rx_cur]) begin
                rx_y[rx_cur] = 1'b1;
                rx_asm_n[int'(rx_r_q + rx_m)*CW +: CW] = link_data_i[int'(rx_cur)*CW +: CW];
                rx_m   = rx_m + idx_t'(1);
                rx_cur = next_ch(rx_cur, mask_q);
            end else begin
                rx_run = 1'b0;
            end
        end
        rx_done     = (rx_m != '0) && ((rx_r_q + rx_m) == LAST);
        rx_stall    = rx_done && out_full_q && !fused_yumi_i;
        link_yumi_o = rx_stall ? '0 : rx_y;
    end

    always_comb begin
        rx_r_d     = rx_r_q;
        rx_ptr_d   = rx_ptr_q;
        rx_asm_d   = rx_asm_q;
        out_full_d = out_full_q;
        out_data_d = out_data_q;
        if (!calib_done_i) begin
            rx_r_d     = '0;
            rx_ptr_d   = lowest_ch(active_channels_i);
            rx_asm_d   = '0;
            out_full_d = 1'b0;
            out_data_d = '0;
        end else begin
            if (out_full_q && fused_yumi_i) out_full_d = 1'b0;
            if (!rx_stall) begin
                rx_ptr_d = rx_cur;
                rx_asm_d = rx_asm_n;
                rx_r_d   = rx_r_q + rx_m;
                if (rx_done) begin
                    rx_r_d     = '0;
                    out_full_d = 1'b1;
                    out_data_d = rx_asm_n;
                end
            end
        end
    end

    // NOTE: the data registers are reset too, because every output must read 0 during reset.
    // NOTE: state is updated with non-blocking assignments so all registers sample together.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mask_q     <= '0;
            tx_full_q  <= 1'b0;
            tx_k_q     <= '0;
            tx_ptr_q   <= '0;
            tx_data_q  <= '0;
            rx_r_q     <= '0;
            rx_ptr_q   <= '0;
            rx_asm_q   <= '0;
            out_full_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            mask_q     <= mask_d;
            tx_full_q  <= tx_full_d;
            tx_k_q     <= tx_k_d;
            tx_ptr_q   <= tx_ptr_d;
            tx_data_q  <= tx_data_d;
            rx_r_q     <= rx_r_d;
            rx_ptr_q   <= rx_ptr_d;
            rx_asm_q   <= rx_asm_d;
            out_full_q <= out_full_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_bsg_comm_link_striper.sv
// Scenario bench for bsg_comm_link_striper: directed cases plus randomized
// loopback traffic checked against a word-level rotation model.
module tb_bsg_comm_link_striper;
    localparam int CW = 8;
    localparam int CC = 3;
    localparam int LC = 4;
    localparam int W  = CC * CW;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            calib;
    logic [LC-1:0]   act;
    logic            fused_v_i, fused_ready_o, fused_v_o, fused_yumi_i;
    logic [W-1:0]    fused_data_i, fused_data_o;
    logic [LC-1:0]   link_v_o, link_ready_i, link_v_i, link_yumi_o;
    logic [LC*CW-1:0] link_data_o, link_data_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]  src_q[$];
    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] chq[LC][$];

    always #5 clk = ~clk;

    bsg_comm_link_striper #(
        .channel_width_p(CW),
        .core_channels_p(CC),
        .link_channels_p(LC)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .calib_done_i     (calib),
        .active_channels_i(act),
        .fused_v_i        (fused_v_i),
        .fused_data_i     (fused_data_i),
        .fused_ready_o    (fused_ready_o),
        .fused_v_o        (fused_v_o),
        .fused_data_o     (fused_data_o),
        .fused_yumi_i     (fused_yumi_i),
        .link_v_o         (link_v_o),
        .link_data_o      (link_data_o),
        .link_ready_i     (link_ready_i),
        .link_v_i         (link_v_i),
        .link_data_i      (link_data_i),
        .link_yumi_o      (link_yumi_o)
    );

    // Rotation helpers: pure spec-level arithmetic on channel numbers.
    function automatic int nxt(input int p, input logic [LC-1:0] m);
        for (int j = 1; j <= LC; j++) begin
            if (m[(p + j) % LC]) return (p + j) % LC;
        end
        return p;
    endfunction

    function automatic int lowest(input logic [LC-1:0] m);
        for (int i = 0; i < LC; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic int advance(input int p, input logic [LC-1:0] m, input int n);
        int q = p;
        for (int i = 0; i < n; i++) q = nxt(q, m);
        return q;
    endfunction

    function automatic logic [LC-1:0] prefix(input int start, input logic [LC-1:0] m,
                                             input logic [LC-1:0] en, input int limit);
        logic [LC-1:0] v = '0;
        int p = start;
        for (int n = 0; n < limit && n < $countones(m); n++) begin
            if (!en[p]) break;
            v[p] = 1'b1;
            p = nxt(p, m);
        end
        return v;
    endfunction

    task automatic idle();
        fused_v_i    = 1'b0;
        fused_data_i = '0;
        fused_yumi_i = 1'b0;
        link_v_i     = '0;
        link_data_i  = '0;
        link_ready_i = '1;
    endtask

    task automatic flush(input logic [LC-1:0] m);
        @(negedge clk);
        idle();
        calib = 1'b0;
        act   = m;
        repeat (2) @(negedge clk);
        calib = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (fused_ready_o !== 1'b0 || fused_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags: ready=%b v=%b want 0 0", fused_ready_o, fused_v_o); end
        n_tests++; if (fused_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", fused_data_o); end
        n_tests++; if (link_v_o !== '0 || link_yumi_o !== '0 || link_data_o !== '0) begin n_fail++; $display("FAIL reset_link: v=%b yumi=%b data=%h want 0", link_v_o, link_yumi_o, link_data_o); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_tests++; if (fused_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_zero_mask_ready: got %b want 0", fused_ready_o); end
    endtask

    task automatic test_tx_stripe();
        flush(4'b1111);
        fused_v_i = 1'b1; fused_data_i = 24'h332211;
        #1;
        n_tests++; if (fused_ready_o !== 1'b1 || link_v_o !== '0) begin n_fail++; $display("FAIL stripe_accept1: ready=%b v=%b want 1 0000", fused_ready_o, link_v_o); end
        @(negedge clk); fused_v_i = 1'b0;
        #1;
        n_tests++; if (link_v_o !== 4'b0111 || link_data_o[23:0] !== 24'h332211) begin n_fail++; $display("FAIL stripe_word1: v=%b data=%h want 0111 332211", link_v_o, link_data_o); end
        @(negedge clk); fused_v_i = 1'b1; fused_data_i = 24'h665544;
        #1;
        n_tests++; if (fused_ready_o !== 1'b1 || link_v_o !== '0) begin n_fail++; $display("FAIL stripe_accept2: ready=%b v=%b want 1 0000", fused_ready_o, link_v_o); end
        @(negedge clk); fused_v_i = 1'b0;
        #1;
        n_tests++; if (link_v_o !== 4'b1011 || {link_data_o[31:24], link_data_o[15:0]} !== 24'h446655) begin n_fail++; $display("FAIL stripe_word2: v=%b data=%h want 1011 44xx6655", link_v_o, link_data_o); end
        @(negedge clk);
        idle();
    endtask

    // Loopback through per-channel FIFOs; model tracks rotation pointers and chunk counts.
    task automatic run_traffic(input logic [LC-1:0] m, input int rdy_pct, input int v_pct,
                               input int yumi_pct, input string name);
        int tx_ptr, rx_ptr, tb_k, tb_r, cyc, cnt;
        bit tx_busy, out_full, prev_hold, was_full;
        logic [W-1:0]  prev_data;
        logic [LC-1:0] ev, ey;
        exp_q.delete();
        for (int c = 0; c < LC; c++) chq[c].delete();
        flush(m);
        tx_ptr = lowest(m); rx_ptr = tx_ptr; tb_k = 0; tb_r = 0;
        tx_busy = 1'b0; out_full = 1'b0; prev_hold = 1'b0; prev_data = '0; cyc = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < 2000) begin
            fused_v_i    = (src_q.size() != 0) && ($urandom_range(99) < v_pct);
            fused_data_i = (src_q.size() != 0) ? src_q[0] : '0;
            for (int c = 0; c < LC; c++) begin
                link_ready_i[c] = ($urandom_range(99) < rdy_pct);
                link_v_i[c]     = (chq[c].size() != 0) && ($urandom_range(99) < v_pct);
                link_data_i[c*CW +: CW] = (chq[c].size() != 0) ? chq[c][0] : '0;
            end
            fused_yumi_i = out_full && ($urandom_range(99) < yumi_pct);
            #1;
            ev = tx_busy ? prefix(tx_ptr, m, link_ready_i, CC - tb_k) : '0;
            ey = prefix(rx_ptr, m, link_v_i, CC - tb_r);
            if (tb_r + $countones(ey) == CC && out_full && !fused_yumi_i) ey = '0;
            n_tests++; if (fused_ready_o !== !tx_busy) begin n_fail++; $display("FAIL %s_ready: got %b want %b", name, fused_ready_o, !tx_busy); end
            n_tests++; if (link_v_o !== ev || (link_v_o & ~m) !== '0) begin n_fail++; $display("FAIL %s_link_v: got %b want %b mask %b", name, link_v_o, ev, m); end
            n_tests++; if (link_yumi_o !== ey) begin n_fail++; $display("FAIL %s_link_yumi: got %b want %b", name, link_yumi_o, ey); end
            n_tests++; if (fused_v_o !== out_full) begin n_fail++; $display("FAIL %s_fused_v: got %b want %b", name, fused_v_o, out_full); end
            if (prev_hold) begin
                n_tests++; if (fused_data_o !== prev_data) begin n_fail++; $display("FAIL %s_hold: got %h want %h", name, fused_data_o, prev_data); end
            end
            if (out_full && fused_yumi_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL %s_extra_word: got %h want none", name, fused_data_o); end
                else if (fused_data_o !== exp_q[0]) begin n_fail++; $display("FAIL %s_word: got %h want %h", name, fused_data_o, exp_q[0]); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            for (int c = 0; c < LC; c++) begin
                if (link_yumi_o[c] && chq[c].size() != 0) void'(chq[c].pop_front());
                if (link_v_o[c] && link_ready_i[c]) chq[c].push_back(link_data_o[c*CW +: CW]);
            end
            if (tx_busy) begin
                cnt = $countones(ev); tb_k += cnt; tx_ptr = advance(tx_ptr, m, cnt);
                if (tb_k == CC) begin tx_busy = 1'b0; tb_k = 0; end
            end else if (fused_v_i) begin
                tx_busy = 1'b1;
                exp_q.push_back(src_q.pop_front());
            end
            was_full = out_full;
            if (out_full && fused_yumi_i) out_full = 1'b0;
            cnt = $countones(ey); tb_r += cnt; rx_ptr = advance(rx_ptr, m, cnt);
            if (tb_r == CC) begin tb_r = 0; out_full = 1'b1; end
            prev_hold = was_full && !fused_yumi_i;
            prev_data = fused_data_o;
            @(negedge clk);
            cyc++;
        end
        n_tests++; if (src_q.size() != 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL %s_drain: %0d unsent %0d undelivered want 0 0", name, src_q.size(), exp_q.size()); end
        src_q.delete();
        idle();
    endtask

    task automatic test_loopback_mask();
        src_q.delete();
        src_q.push_back(24'hA1B2C3);
        src_q.push_back(24'h0F1E2D);
        run_traffic(4'b1010, 100, 100, 100, "mask1010");
    endtask

    task automatic test_ready_stall();
        flush(4'b1111);
        link_ready_i = 4'b1101; fused_v_i = 1'b1; fused_data_i = 24'hCCBBAA;
        #1;
        n_tests++; if (fused_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_accept: got %b want 1", fused_ready_o); end
        @(negedge clk); fused_v_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (i == 0 && (link_v_o !== 4'b0001 || link_data_o[7:0] !== 8'hAA)) begin n_fail++; $display("FAIL stall_first: v=%b ch0=%h want 0001 aa", link_v_o, link_data_o[7:0]); end
            if (i != 0 && link_v_o !== 4'b0000) begin n_fail++; $display("FAIL stall_wait%0d: v=%b want 0000", i, link_v_o); end
            @(negedge clk);
        end
        link_ready_i = '1;
        #1;
        n_tests++; if (link_v_o !== 4'b0110 || link_data_o[23:8] !== 16'hCCBB) begin n_fail++; $display("FAIL stall_resume: v=%b data=%h want 0110 ccbb", link_v_o, link_data_o); end
        @(negedge clk);
        #1;
        n_tests++; if (fused_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_empty: got %b want 1", fused_ready_o); end
        idle();
    endtask

    task automatic test_output_stall();
        flush(4'b1111);
        link_v_i = 4'b0111; link_data_i = 32'h00030201;
        #1;
        n_tests++; if (link_yumi_o !== 4'b0111) begin n_fail++; $display("FAIL ostall_take1: got %b want 0111", link_yumi_o); end
        @(negedge clk);
        link_v_i = 4'b1011; link_data_i = 32'h04000605;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (fused_v_o !== 1'b1 || fused_data_o !== 24'h030201) begin n_fail++; $display("FAIL ostall_hold%0d: v=%b data=%h want 1 030201", i, fused_v_o, fused_data_o); end
            n_tests++; if (link_yumi_o !== 4'b0000) begin n_fail++; $display("FAIL ostall_block%0d: got %b want 0000", i, link_yumi_o); end
            @(negedge clk);
        end
        fused_yumi_i = 1'b1;
        #1;
        n_tests++; if (link_yumi_o !== 4'b1011) begin n_fail++; $display("FAIL ostall_release: got %b want 1011", link_yumi_o); end
        @(negedge clk); fused_yumi_i = 1'b0; link_v_i = '0;
        #1;
        n_tests++; if (fused_v_o !== 1'b1 || fused_data_o !== 24'h060504) begin n_fail++; $display("FAIL ostall_word2: v=%b data=%h want 1 060504", fused_v_o, fused_data_o); end
        @(negedge clk); fused_yumi_i = 1'b1;
        @(negedge clk); fused_yumi_i = 1'b0;
        #1;
        n_tests++; if (fused_v_o !== 1'b0) begin n_fail++; $display("FAIL ostall_taken: got %b want 0", fused_v_o); end
        idle();
    endtask

    task automatic test_flush_mid_word();
        logic [CW-1:0] exp_b[3];
        exp_b[0] = 8'h77; exp_b[1] = 8'h88; exp_b[2] = 8'h99;
        flush(4'b1111);
        link_ready_i = 4'b0001; fused_v_i = 1'b1; fused_data_i = 24'h222120;
        link_v_i = 4'b0111; link_data_i = 32'h00333231;
        @(negedge clk); fused_v_i = 1'b0; link_v_i = '0;
        #1;
        n_tests++; if (link_v_o !== 4'b0001 || fused_v_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre: v=%b fused_v=%b want 0001 1", link_v_o, fused_v_o); end
        @(negedge clk);
        calib = 1'b0; act = 4'b0100; link_ready_i = '1;
        repeat (2) @(negedge clk);
        calib = 1'b1;
        #1;
        n_tests++; if (fused_v_o !== 1'b0 || fused_ready_o !== 1'b1 || link_v_o !== '0) begin n_fail++; $display("FAIL flush_empty: fused_v=%b ready=%b v=%b want 0 1 0000", fused_v_o, fused_ready_o, link_v_o); end
        fused_v_i = 1'b1; fused_data_i = 24'h998877;
        @(negedge clk); fused_v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (link_v_o !== 4'b0100 || link_data_o[23:16] !== exp_b[i]) begin n_fail++; $display("FAIL flush_ch2_%0d: v=%b ch2=%h want 0100 %h", i, link_v_o, link_data_o[23:16], exp_b[i]); end
            @(negedge clk);
        end
        #1;
        n_tests++; if (link_v_o !== '0 || fused_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_done: v=%b ready=%b want 0000 1", link_v_o, fused_ready_o); end
        idle();
    endtask

    task automatic test_random();
        logic [LC-1:0] m;
        for (int it = 0; it < 5; it++) begin
            m = (it == 0) ? 4'b1111 : 4'($urandom_range(1, 15));
            src_q.delete();
            for (int w = 0; w < 10; w++) src_q.push_back(W'($urandom));
            run_traffic(m, 70, 70, 60, "rand");
        end
    endtask

    task automatic test_async_reset();
        flush(4'b1111);
        link_ready_i = 4'b0001; fused_v_i = 1'b1; fused_data_i = 24'h5A5A5A;
        link_v_i = 4'b0111; link_data_i = 32'h00C3B2A1;
        @(negedge clk);
        fused_v_i = 1'b0; link_v_i = 4'b1111; link_ready_i = 4'b1111;
        #1;
        n_tests++; if (fused_v_o !== 1'b1 || link_v_o === '0) begin n_fail++; $display("FAIL areset_pre: fused_v=%b v=%b want 1 nonzero", fused_v_o, link_v_o); end
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (fused_v_o !== 1'b0 || fused_data_o !== '0 || fused_ready_o !== 1'b0) begin n_fail++; $display("FAIL areset_fused: v=%b data=%h ready=%b want 0", fused_v_o, fused_data_o, fused_ready_o); end
        n_tests++; if (link_v_o !== '0 || link_data_o !== '0 || link_yumi_o !== '0) begin n_fail++; $display("FAIL areset_link: v=%b data=%h yumi=%b want 0", link_v_o, link_data_o, link_yumi_o); end
        @(negedge clk);
        reset_n = 1'b1; fused_v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (fused_ready_o !== 1'b0 || link_v_o !== '0 || link_yumi_o !== '0) begin n_fail++; $display("FAIL areset_zero_mask%0d: ready=%b v=%b yumi=%b want 0", i, fused_ready_o, link_v_o, link_yumi_o); end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        calib   = 1'b0;
        act     = '0;
        idle();
        test_reset();
        test_tx_stripe();
        test_loopback_mask();
        test_ready_stall();
        test_output_stall();
        test_flush_mid_word();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_comm_link_striper.md
Name: bsg_comm_link_striper

Overview:
- Parametrised successor to the comm-link fuser.
- Stripes each core word (core_channels_p chunks of channel_width_p bits) across a runtime-selected subset of link channels, and reassembles received chunks into core words in order.
- Issues several chunks per cycle, rotating across channels so the stripe position carries over between words, and stays correct for any nonzero active mask.
- Sits between the core fabric and the per-channel link kernel.

Parameters:
channel_width_p, 16, bits per link chunk
core_channels_p, 3, chunks per core word (may exceed or be less than link_channels_p)
link_channels_p, 4, number of physical link channels
width_p, core_channels_p*channel_width_p, fused word width

Ports:
clk_i  in  1  core clock
reset_n_i  in  1  asynchronous active-low reset
calib_done_i  in  1  link calibrated; low = synchronous flush
active_channels_i  in  link_channels_p  channel enable mask
fused_v_i  in  1  fused word valid
fused_data_i  in  width_p  fused word; chunk j = bits [j*cw +: cw]
fused_ready_o  out  1  striper can accept a word
fused_v_o  out  1  reassembled word valid
fused_data_o  out  width_p  reassembled word
fused_yumi_i  in  1  consumer takes word
link_v_o  out  link_channels_p  per-channel chunk valid
link_data_o  out  link_channels_p*channel_width_p  per-channel chunk
link_ready_i  in  link_channels_p  per-channel ready (valid/ready)
link_v_i  in  link_channels_p  received chunk valid
link_data_i  in  link_channels_p*channel_width_p  received chunks
link_yumi_o  out  link_channels_p  received chunk consumed

Behaviour:
- Reset (reset_n_i low, async): all outputs 0; tx/rx pointers = 0; buffers empty; mask register = 0.
- Flush (calib_done_i low, sync): same state as reset.
- Mask register: loads active_channels_i every cycle while calib_done_i is low; frozen while it is high.
- Zero mask: fused_ready_o = 0, link_v_o = 0, link_yumi_o = 0.
- Pointer advance: tx_ptr and rx_ptr point at an active channel. "next(p)" is the next higher active channel, wrapping to the lowest. Pointers persist across words.
- Pointer init: after flush, each pointer starts at the lowest active channel.

TX (one word register, chunk index k):
- fused_ready_o = tx empty. The word is captured on fused_v_i & fused_ready_o, with k = 0.
- Each cycle, consider the rotating sequence of active channels c0 = tx_ptr, c1 = next(c0), ...
- m = the largest count such that link_ready_i is high on c0..c(m-1), with m ≤ remaining chunks and m ≤ popcount(mask).
- Channel ci is driven with link_v_o = 1 and chunk k+i. This is unconditional: link_v_o does not depend on link_ready_i beyond the prefix rule.
- Then k += m and tx_ptr advances m steps.
- When the last chunk is sent, tx empties, and fused_ready_o rises the next cycle (no same-cycle refill).
- Chunks never skip a not-ready channel, so order is preserved.

RX (assembly register, index r; output register):
- Same prefix rule using link_v_i starting at rx_ptr.
- m ≤ remaining chunks of the current word.
- Assertion is the deciding rule: link_yumi_o[ci] = 1 only for consumed chunks. Chunk i is written to slot r+i. r += m, and rx_ptr advances m steps.
- When the assembly completes, the word moves to the output register in the same cycle, provided the output register is empty or fused_yumi_i is high. Otherwise the assembly stalls: m = 0 until space frees.
- fused_v_o = output register full.
- Latency: a word with all chunks already present appears at fused_v_o one cycle after the last chunk's yumi edge.
- Simultaneous: completion while fused_yumi_i is high replaces the output word with no bubble.
- Output stability: fused_data_o is stable while fused_v_o is high and not yet taken.
- Width: chunk indices use $clog2(core_channels_p+1) bits; pointers use $clog2(link_channels_p) bits (min 1).

Test Plan:
1. Bench configuration: cw=8, cc=3, lc=4, mask=4'b1111, all ready. Send 0x332211 then 0x665544.
   Cycle 1: ch0..2 = 11,22,33. Cycle 2: ch3 = 44, ch0 = 55, ch1 = 66 (pointer carries over).
2. Mask 4'b1010. Loop back tx to rx.
   Words 0xA1B2C3 and 0x0F1E2D are received intact and in order, using only ch1/ch3; link_v_o[0] and link_v_o[2] stay 0.
3. All ready, but link_ready_i[1] = 0 for 5 cycles.
   Only ch0 receives chunk 0. Chunks 1 and 2 wait; no chunk goes to ch2 until ch1 accepts.
4. fused_yumi_i held low with the output register full, plus a second complete word arriving.
   link_yumi_o = 0 and fused_data_o is stable. When yumi is pulsed, the second word appears the next cycle.
5. Drop calib_done_i mid-word (k=1), change mask to 4'b0100, then raise calib_done_i.
   All buffers are empty, fused_v_o = 0, and the next word is sent on ch2 only, over 3 cycles.
6. Assert reset_n_i low asynchronously mid-transfer.
   All outputs are 0 immediately, without waiting for a clock edge. A zero mask afterwards keeps fused_ready_o = 0.
